module_display_scan_ctrl: RTL and testbench

- Time-multiplexes one shared BCD-to-7-segment decoder (module_bcd_decoder, 4-bit w in, 7-bit d out) across N_DIGITS common-anode digits.
- Sequences digit selection with a guard (ghost-suppression) interval and provides leading-zero blanking.
- Accepts new display values through a ready/load handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the application datapath and the decoder/anode pins on the board top level.

---
 rtl/display_pkg.sv | 13 +
 rtl/module_scan_timer.sv | 53 +++++
 rtl/module_display_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_module_display_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/module_scan_timer.sv
// Slot counter and digit index for the display scan; provides look-ahead strobes
// so the controller can register its outputs in step with the counter.
module module_scan_timer #(
    parameter  int N_DIGITS    = 4,
    parameter  int REFRESH_DIV = 27000,
    parameter  int GUARD_CYC   = 270,
    localparam int CW          = $clog2(REFRESH_DIV),
    localparam int IW          = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] digit_idx_o,
    output logic [IW-1:0] idx_next_o,
    output logic          drive_next_o,
    output logic          slot_end_o,
    output logic          frame_end_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_W = CW'(GUARD_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Strobes describe the cycle after the coming edge.
    assign digit_idx_o  = idx_q;
    assign idx_next_o   = idx_d;
    assign drive_next_o = (cnt_d >= GUARD_W);
    assign slot_end_o   = slot_end;
    assign frame_end_o  = slot_end && (idx_q == IDX_MAX);

endmodule

// File: rtl/module_display_scan_ctrl.sv
// Multiplexes one BCD decoder over N_DIGITS common-anode digits with guard slots,
// leading-zero blanking and frame-aligned value updates through a ready/load handshake.
module module_display_scan_ctrl
    import display_pkg::*;
#(
    parameter  int N_DIGITS    = 4,
    parameter  int REFRESH_DIV = 27000,
    parameter  int GUARD_CYC   = 270,
    localparam int IW          = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  ready,
    output logic [3:0]            w,
    output logic [N_DIGITS-1:0]   an,
    output logic [IW-1:0]         digit_idx
);

    // Handshake: a load is accepted in any cycle where load && ready; ready is low
    // only while a captured value waits for the next frame boundary.

    logic [IW-1:0] idx_next;
    logic          drive_next;
    logic          slot_end;
    logic          frame_end;

    module_scan_timer #(
        .N_DIGITS   (N_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .GUARD_CYC  (GUARD_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .digit_idx_o (digit_idx),
        .idx_next_o  (idx_next),
        .drive_next_o(drive_next),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    function automatic bcd_t digit_at(input logic [4*N_DIGITS-1:0] val,
                                      input logic [IW-1:0] idx);
        bcd_t code;
        code = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IW'(j) == idx) code = val[j*4 +: 4];
        end
        return code;
    endfunction

    function automatic logic digit_off(input logic [4*N_DIGITS-1:0] val,
                                       input logic [IW-1:0] idx,
                                       input logic blz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if ((IW'(j) >= idx) && (val[j*4 +: 4] != 4'd0)) upper_zero = 1'b0;
        end
        return (digit_at(val, idx) > BCD_MAX) || (blz && (idx != '0) && upper_zero);
    endfunction

    scan_state_e                state_q;
    logic [4*N_DIGITS-1:0]      disp_q, disp_d;
    logic [4*N_DIGITS-1:0]      pend_buf_q, pend_buf_d;
    logic                       pend_q, pend_d;
    bcd_t                       w_q, w_d;
    logic [N_DIGITS-1:0]        an_q, an_drive;

    always_comb begin
        disp_d     = disp_q;
        pend_buf_d = pend_buf_q;
        pend_d     = pend_q;
        if (frame_end) begin
            if (pend_q) begin
                disp_d = pend_buf_q;
                pend_d = 1'b0;
            end else if (load) begin
                disp_d = bcd_in;
            end
        end else if (load && !pend_q) begin
            pend_buf_d = bcd_in;
            pend_d     = 1'b1;
        end
    end

    // disp_d is used so the first slot of a new frame already shows the new value.
    always_comb begin
        w_d = w_q;
        if (slot_end) w_d = digit_at(disp_d, idx_next);
        an_drive = '1;
        if (!digit_off(disp_d, idx_next, blank_lz)) an_drive[idx_next] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GUARD;
            an_q       <= '1;
            w_q        <= '0;
            disp_q     <= '0;
            pend_buf_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            pend_buf_q <= pend_buf_d;
            pend_q     <= pend_d;
            w_q        <= w_d;
            case (state_q)
                GUARD: begin
                    if (drive_next) begin
                        state_q <= DRIVE;
                        an_q    <= an_drive;
                    end else begin
                        an_q    <= '1;
                    end
                end
                DRIVE: begin
                    if (!drive_next) begin
                        state_q <= GUARD;
                        an_q    <= '1;
                    end else begin
                        an_q    <= an_drive;
                    end
                end
                default: begin
                    state_q <= GUARD;
                    an_q    <= '1;
                end
            endcase
        end
    end

    assign ready = ~pend_q;
    assign w     = w_q;
    assign an    = an_q;

endmodule

// File: tb/tb_module_display_scan_ctrl.sv
// Bench for module_display_scan_ctrl: per-cycle scoreboard of {digit_idx, w, an}
// plus inline handshake and reset checks.
module tb_module_display_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  w;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    always #5 clk = ~clk;

    module_display_scan_ctrl #(
        .N_DIGITS   (N),
        .REFRESH_DIV(RD),
        .GUARD_CYC  (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .ready    (ready),
        .w        (w),
        .an       (an),
        .digit_idx(digit_idx)
    );

    logic [9:0] exp_q[$];
    int total    = 0;
    int bad      = 0;
    int cyc      = -1;
    int push_pos = 0;
    bit sb_en    = 1'b0;

    // Expected {slot, digit code, anodes} for cycle p of a frame showing val.
    function automatic logic [9:0] model_entry(input logic [15:0] val, input logic blz,
                                               input int p);
        int         s;
        int         c;
        logic [3:0] d;
        logic [3:0] a;
        logic       upper_zero;
        logic       supp;
        s = (p / RD) % N;
        c = p % RD;
        d = val[s*4 +: 4];
        upper_zero = 1'b1;
        for (int j = s; j < N; j++) begin
            if (val[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
        end
        supp = (d > 4'd9) || (blz && (s != 0) && upper_zero);
        a = 4'hF;
        if (c >= GC && !supp) a[s] = 1'b0;
        return {2'(s), d, a};
    endfunction

    task automatic push_frame(input logic [15:0] val, input logic blz);
        for (int i = 0; i < FRAME; i++) begin
            exp_q.push_back(model_entry(val, blz, push_pos));
            push_pos++;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty cyc=%0d got idx=%0d w=%h an=%b", cyc, digit_idx, w, an);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({digit_idx, w, an} !== e) begin
                    bad++;
                    $display("FAIL scan cyc=%0d got idx=%0d w=%h an=%b exp idx=%0d w=%h an=%b",
                             cyc, digit_idx, w, an, e[9:8], e[7:4], e[3:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        total++; if (an !== 4'hF) begin bad++; $display("FAIL rst_an got=%b exp=1111", an); end
        total++; if (w !== 4'h0) begin bad++; $display("FAIL rst_w got=%h exp=0", w); end
        total++; if (digit_idx !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", digit_idx); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
        @(posedge clk);
        #2 rst = 1'b0;
        sb_en = 1'b1;
        cyc = -1;
        goto(0);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst got=%b exp=1", ready); end
    endtask

    task automatic test_load();
        goto(38);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_before got=%b exp=1", ready); end
        load = 1'b1; bcd_in = 16'h1234;
        push_frame(16'h1234, 1'b0);
        goto(39);
        load = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL load_ready_fall got=%b exp=0", ready); end
        goto(63);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL load_ready_hold got=%b exp=0", ready); end
        goto(64);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_rise got=%b exp=1", ready); end
    endtask

    task automatic test_load_ignored();
        goto(66);
        load = 1'b1; bcd_in = 16'h1234;
        push_frame(16'h1234, 1'b0);
        goto(67);
        load = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ign_ready_a got=%b exp=0", ready); end
        goto(74);
        load = 1'b1; bcd_in = 16'h5678;
        goto(75);
        load = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ign_ready_b got=%b exp=0", ready); end
    endtask

    task automatic test_blanking();
        goto(99);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL blank_ready got=%b exp=1", ready); end
        load = 1'b1; bcd_in = 16'h0070;
        push_frame(16'h0070, 1'b1);
        goto(100);
        load = 1'b0;
        goto(128);
        blank_lz = 1'b1;
        goto(131);
        load = 1'b1; bcd_in = 16'h0000;
        push_frame(16'h0000, 1'b1);
        goto(132);
        load = 1'b0;
    endtask

    task automatic test_invalid_digit();
        goto(163);
        load = 1'b1; bcd_in = 16'h1A23;
        push_frame(16'h1A23, 1'b0);
        goto(164);
        load = 1'b0;
        goto(192);
        blank_lz = 1'b0;
    endtask

    task automatic test_boundary_load();
        goto(223);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bnd_ready_pre got=%b exp=1", ready); end
        load = 1'b1; bcd_in = 16'h9999;
        push_frame(16'h9999, 1'b0);
        push_frame(16'h9999, 1'b0);
        goto(224);
        load = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bnd_ready_post got=%b exp=1", ready); end
        goto(240);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bnd_ready_mid got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid();
        goto(257);
        load = 1'b1; bcd_in = 16'h4321;
        goto(258);
        load = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_pend_ready got=%b exp=0", ready); end
        goto(260);
        #1 sb_en = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("FAIL mid_rst_an got=%b exp=1111", an); end
        total++; if (w !== 4'h0) begin bad++; $display("FAIL mid_rst_w got=%h exp=0", w); end
        total++; if (digit_idx !== 2'd0) begin bad++; $display("FAIL mid_rst_idx got=%0d exp=0", digit_idx); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
        exp_q.delete();
        push_pos = 0;
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        sb_en = 1'b1;
        cyc = -1;
        goto(63);
        #1 sb_en = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_end_ready got=%b exp=1", ready); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_ignored();
        test_blanking();
        test_invalid_digit();
        test_boundary_load();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
